// File: rtl/divisor_secuencial_4bits_if.sv
// Start/done handshake and operand/result bus for the sequential restoring divider.
interface divisor_secuencial_4bits_if #(
   parameter int unsigned ANCHO = 4
);
   logic             inicio;
   logic [ANCHO-1:0] dividendo;
   logic [ANCHO-1:0] divisor;
   logic [ANCHO-1:0] cociente;
   logic [ANCHO-1:0] residuo;
   logic             ocupado;
   logic             listo;
   logic             div_cero;

   modport master (
      output inicio, dividendo, divisor,
      input  cociente, residuo, ocupado, listo, div_cero
   );

   modport slave (
      input  inicio, dividendo, divisor,
      output cociente, residuo, ocupado, listo, div_cero
   );
endinterface

// File: rtl/divisor_secuencial_4bits.sv
// Sequential restoring divider: one quotient bit per clock via a borrow-ripple trial subtraction.
module divisor_secuencial_4bits #(
   parameter int unsigned ANCHO = 4
) (
   input logic                       clk,
   input logic                       rst,
   divisor_secuencial_4bits_if.slave bus
);

   localparam int unsigned CntW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

   typedef enum logic [1:0] {Reposo, Calculo, Fin} estado_t;

   estado_t          estadoQ, estadoD;
   logic [ANCHO-1:0] aQ, aD;
   logic [ANCHO-1:0] dQ, dD;
   // Top bit of the partial remainder is always 0 after a committed step, so it is not stored.
   logic [ANCHO-1:0] pQ, pD;
   logic [CntW-1:0]  cntQ, cntD;
   logic [ANCHO-1:0] cocienteQ, cocienteD;
   logic [ANCHO-1:0] residuoQ, residuoD;
   logic             ocupadoQ, ocupadoD;
   logic             listoQ, listoD;
   logic             divCeroQ, divCeroD;

   logic [ANCHO:0]   trial;
   logic [ANCHO:0]   dExt;
   logic [ANCHO-1:0] dif;
   logic             borrowOut;
   logic             bitCociente;

   // Borrow-ripple chain of full-subtractor cells, borrow-in 0.
   always_comb begin
      logic b;
      trial = {pQ, aQ[ANCHO-1]};
      dExt  = {1'b0, dQ};
      dif   = '0;
      b     = 1'b0;
      for (int i = 0; i < ANCHO; i++) begin
         dif[i] = trial[i] ^ dExt[i] ^ b;
         b      = (~trial[i] & dExt[i]) | (~(trial[i] ^ dExt[i]) & b);
      end
      borrowOut   = (~trial[ANCHO] & dExt[ANCHO]) | (~(trial[ANCHO] ^ dExt[ANCHO]) & b);
      bitCociente = ~borrowOut;
   end

   always_comb begin
      estadoD   = estadoQ;
      aD        = aQ;
      dD        = dQ;
      pD        = pQ;
      cntD      = cntQ;
      cocienteD = cocienteQ;
      residuoD  = residuoQ;
      divCeroD  = divCeroQ;

      unique case (estadoQ)
         Reposo: begin
            if (bus.inicio) begin
               if (bus.divisor != '0) begin
                  aD       = bus.dividendo;
                  dD       = bus.divisor;
                  pD       = '0;
                  cntD     = '0;
                  divCeroD = 1'b0;
                  estadoD  = Calculo;
               end else begin
                  cocienteD = '1;
                  residuoD  = bus.dividendo;
                  divCeroD  = 1'b1;
                  estadoD   = Fin;
               end
            end
         end
         Calculo: begin
            pD   = borrowOut ? trial[ANCHO-1:0] : dif;
            aD   = {aQ[ANCHO-2:0], bitCociente};
            cntD = cntQ + 1'b1;
            if (cntQ == CntW'(ANCHO - 1)) begin
               cocienteD = aD;
               residuoD  = pD;
               estadoD   = Fin;
            end
         end
         Fin: begin
            estadoD = Reposo;
         end
         default: begin
            estadoD = Reposo;
         end
      endcase

      // Registered status derived from the next state, never directly from inicio.
      ocupadoD = (estadoD != Reposo);
      listoD   = (estadoD == Fin);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estadoQ   <= Reposo;
         aQ        <= '0;
         dQ        <= '0;
         pQ        <= '0;
         cntQ      <= '0;
         cocienteQ <= '0;
         residuoQ  <= '0;
         ocupadoQ  <= 1'b0;
         listoQ    <= 1'b0;
         divCeroQ  <= 1'b0;
      end else begin
         estadoQ   <= estadoD;
         aQ        <= aD;
         dQ        <= dD;
         pQ        <= pD;
         cntQ      <= cntD;
         cocienteQ <= cocienteD;
         residuoQ  <= residuoD;
         ocupadoQ  <= ocupadoD;
         listoQ    <= listoD;
         divCeroQ  <= divCeroD;
      end
   end

   assign bus.cociente = cocienteQ;
   assign bus.residuo  = residuoQ;
   assign bus.ocupado  = ocupadoQ;
   assign bus.listo    = listoQ;
   assign bus.div_cero = divCeroQ;

endmodule

// File: tb/tb_divisor_secuencial_4bits.sv
// Directed and exhaustive bench for divisor_secuencial_4bits: results, listo latency, ocupado span.
module tb_divisor_secuencial_4bits;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   divisor_secuencial_4bits_if #(.ANCHO(4)) bus ();

   divisor_secuencial_4bits #(.ANCHO(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Starts one division and follows it until ocupado falls; leaves the bench mid-cycle in REPOSO.
   // With hold set, inicio stays high and the operands switch to hDvd/hDvs right after acceptance.
   task automatic runDiv(input int dvd, input int dvs, input bit hold, input int hDvd,
                         input int hDvs);
      int expQ, expR, expZ, expLat, expOc;
      int lat, oc, nListo, prevQ, prevR;
      string id;
      id = $sformatf("%0d/%0d", dvd, dvs);
      if (dvs == 0) begin
         expQ = 15; expR = dvd; expZ = 1; expLat = 0; expOc = 1;
      end else begin
         expQ = dvd / dvs; expR = dvd % dvs; expZ = 0; expLat = 4; expOc = 5;
      end
      @(negedge clk);
      prevQ = int'(bus.cociente);
      prevR = int'(bus.residuo);
      bus.inicio    = 1'b1;
      bus.dividendo = 4'(dvd);
      bus.divisor   = 4'(dvs);
      @(posedge clk);
      #1;
      if (hold) begin
         bus.dividendo = 4'(hDvd);
         bus.divisor   = 4'(hDvs);
      end else begin
         bus.inicio = 1'b0;
      end
      lat = -1; oc = 0; nListo = 0;
      for (int k = 0; k < 10; k++) begin
         if (k < expLat) begin
            check({"hold cociente ", id}, int'(bus.cociente), prevQ);
            check({"hold residuo ", id}, int'(bus.residuo), prevR);
         end
         if (bus.listo === 1'b1) begin
            nListo++;
            lat = k;
            check({"cociente ", id}, int'(bus.cociente), expQ);
            check({"residuo ", id}, int'(bus.residuo), expR);
            check({"div_cero ", id}, int'(bus.div_cero), expZ);
         end
         if (bus.ocupado === 1'b1) oc++;
         else break;
         @(posedge clk);
         #1;
      end
      check({"listo latency ", id}, lat, expLat);
      check({"listo pulses ", id}, nListo, 1);
      check({"ocupado cycles ", id}, oc, expOc);
   endtask

   initial begin
      int nListo;
      rst           = 1'b1;
      bus.inicio    = 1'b0;
      bus.dividendo = 4'd0;
      bus.divisor   = 4'd0;
      #12;
      check("reset cociente", int'(bus.cociente), 0);
      check("reset residuo", int'(bus.residuo), 0);
      check("reset ocupado", int'(bus.ocupado), 0);
      check("reset listo", int'(bus.listo), 0);
      check("reset div_cero", int'(bus.div_cero), 0);
      @(negedge clk);
      rst = 1'b0;

      runDiv(13, 3, 1'b0, 0, 0);

      // Back-to-back edge values: each start is issued the cycle after ocupado falls.
      runDiv(15, 1, 1'b0, 0, 0);
      runDiv(2, 7, 1'b0, 0, 0);
      runDiv(15, 15, 1'b0, 0, 0);
      runDiv(0, 5, 1'b0, 0, 0);

      runDiv(9, 0, 1'b0, 0, 0);
      runDiv(8, 2, 1'b0, 0, 0);

      // inicio held with new operands during a running 13/3; 6/2 is taken on the next REPOSO edge.
      runDiv(13, 3, 1'b1, 6, 2);
      runDiv(6, 2, 1'b0, 0, 0);

      // Asynchronous reset two edges into a division.
      @(negedge clk);
      bus.inicio    = 1'b1;
      bus.dividendo = 4'd13;
      bus.divisor   = 4'd3;
      @(posedge clk);
      #1;
      bus.inicio = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre-rst ocupado", int'(bus.ocupado), 1);
      rst = 1'b1;
      #1;
      check("async rst cociente", int'(bus.cociente), 0);
      check("async rst residuo", int'(bus.residuo), 0);
      check("async rst ocupado", int'(bus.ocupado), 0);
      check("async rst listo", int'(bus.listo), 0);
      check("async rst div_cero", int'(bus.div_cero), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      nListo = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (bus.listo === 1'b1) nListo++;
      end
      check("no listo after rst", nListo, 0);
      runDiv(14, 4, 1'b0, 0, 0);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            runDiv(a, b, 1'b0, 0, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/divisor_secuencial_4bits.md
# divisor_secuencial_4bits

Sequential restoring divider for unsigned 4-bit operands. It sits downstream of the 4-bit borrow-ripple subtractor stage and uses its result and final borrow to make each quotient-bit decision. It takes one quotient bit per clock and returns quotient, remainder and a divide-by-zero flag under a start/done handshake. It is the first multi-cycle arithmetic block in the basic-arithmetic set.

## Interface
- ANCHO, 4, operand/result width in bits; only 4 is verified
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- inicio  input  1  start request, sampled only in REPOSO
- dividendo  input  ANCHO  unsigned dividend, sampled with inicio
- divisor  input  ANCHO  unsigned divisor, sampled with inicio
- cociente  output  ANCHO  quotient, registered
- residuo  output  ANCHO  remainder, registered
- ocupado  output  1  high while a division is in progress (CALCULO or FIN)
- listo  output  1  one-cycle pulse: results valid and just updated
- div_cero  output  1  sticky error for the last accepted division: divisor was 0

## Operation
- Reset (rst=1, asynchronous): state=REPOSO; cociente, residuo, ocupado, listo and div_cero all 0; internal counter and partial remainder cleared.
- FSM states: REPOSO, CALCULO, FIN.
- REPOSO:
  - inicio=1 with divisor≠0: latch dividendo into shift register A and divisor into D; partial remainder P (ANCHO+1 bits) = 0; counter = 0; clear div_cero; go to CALCULO.
  - inicio=1 with divisor=0: cociente=all ones (4'hF); residuo=dividendo; div_cero=1; go to FIN.
  - inicio=0: stay in REPOSO.
- CALCULO, one step per clock:
  - T = {P[ANCHO-1:0], A[ANCHO-1]}.
  - Trial difference S = T − {0,D}, computed by an (ANCHO+1)-bit borrow-ripple subtractor made of full-subtractor cells with borrow-in 0.
  - Borrow-out=0: P=S and the quotient bit is 1.
  - Borrow-out=1: P=T (restore) and the quotient bit is 0.
  - A shifts left with the quotient bit entering at bit 0.
  - Counter increments.
  - On the step where the counter reaches ANCHO−1: write cociente=A (new value) and residuo=P[ANCHO-1:0] (new value), then go to FIN.
- FIN: listo=1 for exactly this cycle, then REPOSO unconditionally.
- inicio is ignored in CALCULO and FIN; no queuing.
- cociente, residuo and div_cero hold their last values until the next FIN; they do not change during CALCULO.
- Width rule: the remainder is always < divisor, so residuo fits in ANCHO bits. P[ANCHO] is 0 after every committed step.

## Timing
- Accept edge = the rising edge on which REPOSO samples inicio=1.
- Normal division: ANCHO (4) CALCULO steps on the accept edge +1 … +4. Results are written at edge +4. listo=1 during the cycle after edge +4. Back in REPOSO after edge +5.
- ocupado=1 from after the accept edge until after edge +5 (5 cycles). A new inicio can be accepted at edge +6 at the earliest.
- Divide by zero: results written at the accept edge. listo=1 during the cycle after it. REPOSO after accept +1. ocupado is high for 1 cycle.
- listo and ocupado are registered; neither is combinational from inicio.
- rst asserted mid-operation: all outputs go to 0 immediately, without waiting for a clock. The in-flight division is discarded. The first inicio after rst deasserts is accepted normally.

## Test plan
- 13 / 3: inicio for 1 cycle → listo exactly 4 cycles after the accept edge, cociente=4, residuo=1, div_cero=0, ocupado high 5 cycles.
- Edge values: 15/1 → 15,0; 2/7 → 0,2; 15/15 → 1,0; 0/5 → 0,0. Run back-to-back, with inicio reasserted the cycle after ocupado falls.
- 9 / 0 → listo 1 cycle after accept, cociente=15, residuo=9, div_cero=1. A following 8/2 → 4,0 with div_cero cleared.
- inicio held high with new operands (6/2) throughout a running 13/3 → result 4,1. Exactly one listo pulse, then 6/2 is accepted only on the next REPOSO sample.
- rst pulsed 2 cycles into 13/3 → all outputs 0 asynchronously, no listo. A subsequent 14/4 → 3,2.
- Exhaustive sweep of all 256 operand pairs against a software model, including listo timing for each.
